// File: rtl/panxi_ram_arb.sv
// panxi_ram_arb: shares one single-port RAM between fetch (I) and load/store (D).
// Define PANXI_RAM_ARB_RR_EN for round-robin arbitration instead of D-over-I.
module panxi_ram_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    ACLK,
   input  logic                    ARST,
   input  logic                    I_REQ,
   input  logic [ADDR_WIDTH-1:0]   I_ADDR,
   output logic                    I_GNT,
   output logic                    I_RVALID,
   output logic [DATA_WIDTH-1:0]   I_RDATA,
   input  logic                    D_REQ,
   input  logic                    D_WE,
   input  logic [DATA_WIDTH/8-1:0] D_BE,
   input  logic [ADDR_WIDTH-1:0]   D_ADDR,
   input  logic [DATA_WIDTH-1:0]   D_WDATA,
   output logic                    D_GNT,
   output logic                    D_RVALID,
   output logic [DATA_WIDTH-1:0]   D_RDATA,
   output logic [ADDR_WIDTH-1:0]   M_ADDR,
   output logic [DATA_WIDTH-1:0]   M_WDATA,
   output logic                    M_WEN,
   input  logic [DATA_WIDTH-1:0]   M_RDATA
);

   localparam int NB = DATA_WIDTH / 8;

   typedef enum logic {
      IDLE,
      RMW
   } state_t;

   state_t                  state;
   logic                    i_pend;
   logic                    d_pend;
   logic [ADDR_WIDTH-1:0]   rmw_addr;
   logic [NB-1:0]           rmw_be;
   logic [DATA_WIDTH-1:0]   rmw_wdata;
   logic [DATA_WIDTH-1:0]   merged;
   logic                    can_grant;
   logic                    d_win;
   logic                    d_full;
   logic                    d_part;

   assign can_grant = (state == IDLE) && !ARST;

`ifdef PANXI_RAM_ARB_RR_EN
   // last_i set means I was granted last, so D wins the next tie
   logic last_i;
   assign d_win = D_REQ && (!I_REQ || last_i);
`else
   assign d_win = D_REQ;
`endif

   assign D_GNT = can_grant && d_win;
   assign I_GNT = can_grant && I_REQ && !d_win;

   assign d_full = D_WE && (&D_BE);
   assign d_part = D_WE && (|D_BE) && !(&D_BE);

   always_comb begin
      merged = M_RDATA;
      for (int b = 0; b < NB; b++) begin
         if (rmw_be[b]) begin
            merged[b*8 +: 8] = rmw_wdata[b*8 +: 8];
         end
      end
   end

   always_comb begin
      M_ADDR  = D_ADDR;
      M_WDATA = D_WDATA;
      M_WEN   = 1'b0;
      if (state == RMW) begin
         M_ADDR  = rmw_addr;
         M_WDATA = merged;
         M_WEN   = !ARST;
      end else if (D_GNT) begin
         M_WEN   = d_full;
      end else if (I_GNT) begin
         M_ADDR  = I_ADDR;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         state  <= IDLE;
         i_pend <= 1'b0;
         d_pend <= 1'b0;
`ifdef PANXI_RAM_ARB_RR_EN
         last_i <= 1'b1;
`endif
      end else begin
         i_pend <= I_GNT;
         d_pend <= D_GNT && !d_part;
`ifdef PANXI_RAM_ARB_RR_EN
         if (I_GNT || D_GNT) begin
            last_i <= I_GNT;
         end
`endif
         unique case (state)
            IDLE: begin
               if (D_GNT && d_part) begin
                  state     <= RMW;
                  rmw_addr  <= D_ADDR;
                  rmw_be    <= D_BE;
                  rmw_wdata <= D_WDATA;
               end
            end
            RMW: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // RAM is write-first, so M_RDATA already holds a full store's word
   assign I_RVALID = i_pend && !ARST;
   assign I_RDATA  = M_RDATA;
   assign D_RVALID = (d_pend || (state == RMW)) && !ARST;
   assign D_RDATA  = (state == RMW) ? merged : M_RDATA;

endmodule

// File: tb/tb_panxi_ram_arb.sv
// tb_panxi_ram_arb: directed bench with a RAM model and response scoreboards.
// Build with PANXI_RAM_ARB_RR_EN to check round-robin grant order.
module tb_panxi_ram_arb;

   logic        clk;
   logic        arst;
   logic        i_req;
   logic [9:0]  i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [9:0]  d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic [9:0]  m_addr;
   logic [31:0] m_wdata;
   logic        m_wen;
   logic [31:0] m_rdata;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        iq[$];
   exp_t        dq[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [31:0] mem [1024];

   panxi_ram_arb dut (
      .ACLK(clk), .ARST(arst),
      .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt),
      .I_RVALID(i_rvalid), .I_RDATA(i_rdata),
      .D_REQ(d_req), .D_WE(d_we), .D_BE(d_be), .D_ADDR(d_addr),
      .D_WDATA(d_wdata), .D_GNT(d_gnt), .D_RVALID(d_rvalid),
      .D_RDATA(d_rdata),
      .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_WEN(m_wen),
      .M_RDATA(m_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // single-port RAM, 1-cycle latency, write-first
   always @(posedge clk) begin
      if (m_wen) begin
         mem[m_addr] <= m_wdata;
         m_rdata     <= m_wdata;
      end else begin
         m_rdata <= mem[m_addr];
      end
   end

   function automatic logic [31:0] init_word(input int a);
      return 32'hA500_0000 | a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // response monitor: RVALID must appear exactly on the due cycle
   always @(negedge clk) begin
      logic ie;
      logic de;
      ie = (iq.size() > 0) && (iq[0].due == cyc);
      de = (dq.size() > 0) && (dq[0].due == cyc);
      chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, ie});
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, de});
      if (ie) begin
         chk("i_rdata", i_rdata, iq[0].data);
         void'(iq.pop_front());
      end
      if (de) begin
         chk("d_rdata", d_rdata, dq[0].data);
         void'(dq.pop_front());
      end
   end

   task automatic step(input logic rst,
                       input logic ir, input logic [9:0] ia,
                       input logic dr, input logic dwe, input logic [3:0] be,
                       input logic [9:0] da, input logic [31:0] wd,
                       input logic eig, input logic edg,
                       input logic [31:0] iexp, input logic [31:0] dexp,
                       input logic dpush, input string tag);
      @(posedge clk);
      #1;
      arst    = rst;
      i_req   = ir;
      i_addr  = ia;
      d_req   = dr;
      d_we    = dwe;
      d_be    = be;
      d_addr  = da;
      d_wdata = wd;
      @(negedge clk);
      chk({tag, "_ignt"}, {31'd0, i_gnt}, {31'd0, eig});
      chk({tag, "_dgnt"}, {31'd0, d_gnt}, {31'd0, edg});
      if (eig) iq.push_back('{iexp, cyc + 1});
      if (edg && dpush) dq.push_back('{dexp, cyc + 1});
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 4'h0, 10'd0, 32'd0,
           1'b0, 1'b0, 32'd0, 32'd0, 1'b0, tag);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
      arst = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;

      // reset with both ports requesting
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 10'd4, 1'b1, 1'b0, 4'h0, 10'd3, 32'd0,
              1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "rst");
         chk("rst_wen", {31'd0, m_wen}, 32'd0);
      end

      // contention straight out of reset: D first
`ifdef PANXI_RAM_ARB_RR_EN
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 10'd4, 1'b1, 1'b0, 4'h0, 10'd3, 32'd0,
              (k % 2) == 1, (k % 2) == 0,
              init_word(4), init_word(3), 1'b1, "cont_rr");
      end
`else
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 10'd4, 1'b1, 1'b0, 4'h0, 10'd3, 32'd0,
              1'b0, 1'b1, init_word(4), init_word(3), 1'b1, "cont_fix");
      end
`endif

      // full store then load, same address
      step(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF,
           1'b0, 1'b1, 32'd0, 32'hDEADBEEF, 1'b1, "st_full");
      chk("st_full_wen", {31'd0, m_wen}, 32'd1);
      step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 4'h0, 10'd5, 32'd0,
           1'b0, 1'b1, 32'd0, 32'hDEADBEEF, 1'b1, "ld_after");

      // partial store; I read of same word blocked in RMW cycle
      step(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 4'h1, 10'd5, 32'h000000AA,
           1'b0, 1'b1, 32'd0, 32'hDEADBEAA, 1'b1, "st_part");
      chk("st_part_wen", {31'd0, m_wen}, 32'd0);
      step(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 4'h0, 10'd0, 32'd0,
           1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "rmw");
      chk("rmw_wen", {31'd0, m_wen}, 32'd1);
      chk("rmw_addr", {22'd0, m_addr}, 32'd5);
      chk("rmw_wdata", m_wdata, 32'hDEADBEAA);
      step(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 4'h0, 10'd0, 32'd0,
           1'b1, 1'b0, 32'hDEADBEAA, 32'd0, 1'b0, "hazard_rd");

      // back-to-back fetches
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 10'(k), 1'b0, 1'b0, 4'h0, 10'd0, 32'd0,
              1'b1, 1'b0, init_word(k), 32'd0, 1'b0, "i_b2b");
      end
      idle("idle0");

      // reset during RMW leaves word 7 untouched
      step(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 4'hF, 10'd7, 32'h11223344,
           1'b0, 1'b1, 32'd0, 32'h11223344, 1'b1, "st7");
      step(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 4'h1, 10'd7, 32'h000000FF,
           1'b0, 1'b1, 32'd0, 32'd0, 1'b0, "st7_part");
      step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 4'h0, 10'd0, 32'd0,
           1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "rmw_rst");
      chk("rmw_rst_wen", {31'd0, m_wen}, 32'd0);
      step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 4'h0, 10'd7, 32'd0,
           1'b0, 1'b1, 32'd0, 32'h11223344, 1'b1, "ld7");

      // pending RVALID dropped by reset
      step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 4'h0, 10'd3, 32'd0,
           1'b0, 1'b1, 32'd0, 32'd0, 1'b0, "ld_pre_rst");
      step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 4'h0, 10'd0, 32'd0,
           1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "pend_rst");

      // zero-BE store writes nothing
      step(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 4'h0, 10'd9, 32'h12345678,
           1'b0, 1'b1, 32'd0, init_word(9), 1'b1, "st_zero");
      chk("st_zero_wen", {31'd0, m_wen}, 32'd0);
      idle("idle1");
      idle("idle2");

      chk("iq_empty", iq.size(), 32'd0);
      chk("dq_empty", dq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/panxi_ram_arb.md
# panxi_ram_arb

Two-port arbiter and sequencer in front of one single-port synchronous RAM, `panxi_ram`. It shares that RAM between the core's instruction-fetch port (I, read-only) and its load/store port (D, read/write with byte enables). The RAM has no byte enables, so partial-word stores run as a two-cycle read-modify-write (RMW). The block sits between the RV32 core bus and the RAM instance.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width; must be a multiple of 8.
- `ADDR_WIDTH`, 10, word-address width; matches the RAM.

Ports:
- `ACLK`, in, 1, clock; all logic on the rising edge.
- `ARST`, in, 1, reset; synchronous, active-high.
- `I_REQ`, in, 1, fetch request.
- `I_ADDR`, in, `ADDR_WIDTH`, fetch word address.
- `I_GNT`, out, 1, fetch accepted this cycle.
- `I_RVALID`, out, 1, fetch data valid.
- `I_RDATA`, out, `DATA_WIDTH`, fetch data.
- `D_REQ`, in, 1, load/store request.
- `D_WE`, in, 1, 1 = store, 0 = load.
- `D_BE`, in, `DATA_WIDTH/8`, byte enables for stores.
- `D_ADDR`, in, `ADDR_WIDTH`, word address.
- `D_WDATA`, in, `DATA_WIDTH`, store data, byte-lane aligned.
- `D_GNT`, out, 1, load/store accepted this cycle.
- `D_RVALID`, out, 1, load data valid or store acknowledge.
- `D_RDATA`, out, `DATA_WIDTH`, load data.
- `M_ADDR`, out, `ADDR_WIDTH`, RAM address.
- `M_WDATA`, out, `DATA_WIDTH`, RAM write data.
- `M_WEN`, out, 1, RAM write enable.
- `M_RDATA`, in, `DATA_WIDTH`, RAM data out; 1-cycle latency, write-first.

## Operation
- **Handshake.** A request is accepted when REQ and GNT are both high in the same cycle. Address, WE, BE and WDATA are sampled only in that cycle. After GNT the requester may present a new request the very next cycle.
- **GNT generation.**
  - GNT is combinational from REQ, `state` and the arbitration pointer.
  - At most one GNT is high per cycle.
  - No GNT is given while `ARST` is high or while `state` is RMW.
- **State machine.**
  - `IDLE`: arbitrate and issue the granted access to the RAM in the same cycle.
  - `IDLE` → `RMW` when the granted access is a D store with partial BE, i.e. BE neither all-ones nor all-zeros.
  - `RMW` → `IDLE` always, after exactly one cycle.
- **I read.** `M_ADDR = I_ADDR`, `M_WEN = 0`. The next cycle `I_RVALID = 1` and `I_RDATA = M_RDATA`.
- **D load, or store with all-zero BE.** Issued as a read. The next cycle `D_RVALID = 1`. Store with zero BE: no RAM write.
- **D store, full BE.** `M_WEN = 1`, `M_WDATA = D_WDATA`, done in one cycle. The next cycle `D_RVALID = 1`.
- **D store, partial BE.**
  - Grant cycle: read of `D_ADDR`. Address, BE and WDATA are registered.
  - RMW cycle: `M_ADDR` = registered address, `M_WEN = 1`. Each byte of `M_WDATA` comes from the registered WDATA where BE is set, otherwise from `M_RDATA`.
  - `D_RVALID = 1` in the RMW cycle.
- **D_RDATA.** Equals `M_RDATA` on a load. On a store it equals the word written to the RAM (merged word for an RMW).
- **Idle cycles.** `M_WEN = 0`; `M_ADDR` and `M_WDATA` are don't-care.
- **Arbitration default.** D has fixed priority over I. The macro below changes this.

## Timing
- **Reset values.** `I_RVALID = 0`, `D_RVALID = 0`, `state = IDLE`, arbitration pointer favours D. `I_GNT`, `D_GNT` and `M_WEN` are 0 while `ARST` is high.
- **Read latency.** Exactly 1 cycle from GNT to RVALID.
- **Store acknowledge latency.** Exactly 1 cycle from GNT to `D_RVALID`, for both the full-BE and the RMW path.
- **Throughput.**
  - One access per cycle for reads and full-BE stores.
  - A partial store occupies 2 cycles; neither port is granted in the RMW cycle.
- **Hazard.** An I read of the address being RMW-written cannot be issued in the RMW cycle. It is issued the cycle after and returns the merged word.
- **Back-to-back D store then read, same address.** The read returns the new data, because the RAM is write-first.
- **Reset mid-RMW.** When `ARST` is high during the RMW cycle, the write is suppressed (`M_WEN = 0`), the RAM is unchanged and `D_RVALID` stays 0.
- **Pending RVALID at reset.** A pending RVALID is cleared by a synchronous reset in the cycle where it would otherwise assert.

## Configuration
- `PANXI_RAM_ARB_RR_EN`
  - Defined: round-robin arbitration. A 1-bit pointer records the last granted port. When both request in `IDLE`, the port not last granted wins. The pointer updates on every grant and resets to "I last", so D wins first.
  - Undefined: fixed D-over-I priority, and no pointer flop exists.

## Test plan
- **Reset.** Hold `ARST` for 3 cycles with both REQ high → no GNT, `M_WEN = 0`, both RVALIDs 0. The first grant after release goes to D.
- **Full store, then load.** D store of `0xDEADBEEF`, BE = `1111`, to address 5; D load from address 5 the next cycle → 1 cycle after the load GNT, `D_RVALID = 1` and `D_RDATA = 0xDEADBEEF`.
- **Partial store.** Word 5 holds `0xDEADBEEF`; D store of `0x000000AA`, BE = `0001` → `D_GNT` then one idle-grant cycle with `M_WEN = 1` and `M_WDATA = 0xDEADBEAA`. A subsequent I read of address 5 returns `0xDEADBEAA`.
- **Contention.** Both ports request continuously for 4 cycles.
  - Without the macro: `D_GNT` 4 times, `I_GNT` 0 times.
  - With `PANXI_RAM_ARB_RR_EN`: the grant order is D, I, D, I.
- **Reset during RMW.** Word 7 holds `0x11223344`; partial store to address 7 with `ARST` high in the RMW cycle → word 7 still reads `0x11223344` and no `D_RVALID` appears.
- **Back-to-back I reads.** I requests to addresses 0, 1, 2 on consecutive cycles with D idle → `I_GNT` high 3 cycles and `I_RVALID` high 3 cycles, each one cycle later, with data in order.
